// File: rtl/averager_readout.sv
// Averager result readout: BRAM port-B frame reader feeding an AXI-Stream
// master through a small credit-managed FIFO that absorbs read latency.
module averager_readout #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int NAVG_WIDTH   = 24,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ready,
    input  logic [NAVG_WIDTH-1:0] n_avg,
    input  logic [31:0]           period,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_en,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [NAVG_WIDTH-1:0] frame_n_avg,
    output logic                  busy,
    output logic [15:0]           overrun_cnt
);

    localparam int DEPTH = BRAM_LATENCY + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int LW    = ADDR_WIDTH + 1;

    localparam logic [0:0]    S_IDLE = 1'b0;
    localparam logic [0:0]    S_READ = 1'b1;
    localparam logic [32:0]   MAX_LEN = 33'd1 << ADDR_WIDTH;
    localparam logic [CW-1:0] CREDIT_INIT = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [0:0]              state_q, state_d;
    logic                    ready_q;
    logic [LW-1:0]           len_q, len_d;
    logic [LW-1:0]           issued_q, issued_d;
    logic [LW-1:0]           sent_q, sent_d;
    logic [CW-1:0]           credit_q, credit_d;
    logic [BRAM_LATENCY-1:0] en_pipe_q, en_pipe_d;
    logic [PW-1:0]           wr_q, wr_d;
    logic [PW-1:0]           rd_q, rd_d;
    logic [CW-1:0]           count_q, count_d;
    logic [NAVG_WIDTH-1:0]   navg_q, navg_d;
    logic [15:0]             overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [32:0]             len_full;
    logic [LW-1:0]           len_clip;
    logic [BRAM_LATENCY:0]   en_shift;
    logic                    rise, issue, push, pop, valid, last_beat;

    // Length is computed in 33 bits so period=32'hFFFFFFFF cannot wrap.
    assign len_full  = {1'b0, period} + 33'd1;
    assign len_clip  = (len_full > MAX_LEN) ? LW'(MAX_LEN) : len_full[LW-1:0];

    assign rise      = ready & ~ready_q;
    assign issue     = (state_q == S_READ) && (issued_q < len_q)
                       && (credit_q != '0);
    assign push      = en_pipe_q[BRAM_LATENCY-1];
    assign valid     = (count_q != '0);
    assign pop       = valid & m_axis_tready;
    assign last_beat = (sent_q == len_q - LW'(1));
    assign en_shift  = {en_pipe_q, issue};

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        issued_d  = issued_q;
        sent_d    = sent_q;
        credit_d  = credit_q;
        navg_d    = navg_q;
        overrun_d = overrun_q;
        en_pipe_d = en_shift[BRAM_LATENCY-1:0];
        wr_d      = wr_q;
        rd_d      = rd_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        if (state_q == S_IDLE) begin
            if (rise) begin
                state_d  = S_READ;
                len_d    = len_clip;
                navg_d   = n_avg;
                issued_d = '0;
                sent_d   = '0;
                credit_d = CREDIT_INIT;
            end
        end else begin
            if (issue) issued_d = issued_q + LW'(1);
            if (pop) sent_d = sent_q + LW'(1);
            credit_d = credit_q + CW'(pop) - CW'(issue);
            if (pop && last_beat) state_d = S_IDLE;
            if (rise && overrun_q != 16'hFFFF) overrun_d = overrun_q + 16'd1;
        end
        if (push) wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + PW'(1);
        if (pop) rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            len_q     <= '0;
            issued_q  <= '0;
            sent_q    <= '0;
            credit_q  <= CREDIT_INIT;
            en_pipe_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            navg_q    <= '0;
            overrun_q <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready;
            len_q     <= len_d;
            issued_q  <= issued_d;
            sent_q    <= sent_d;
            credit_q  <= credit_d;
            en_pipe_q <= en_pipe_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            navg_q    <= navg_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= bram_rdata;
    end

    assign bram_en       = issue;
    assign bram_addr     = issued_q[ADDR_WIDTH-1:0];
    assign m_axis_tvalid = valid;
    assign m_axis_tdata  = valid ? mem[rd_q] : '0;
    assign m_axis_tuser  = valid && (sent_q == '0);
    assign m_axis_tlast  = valid && last_beat;
    assign frame_n_avg   = navg_q;
    assign busy          = (state_q == S_READ);
    assign overrun_cnt   = overrun_q;

endmodule

// File: tb/tb_averager_readout.sv
// Directed bench for averager_readout: BRAM model returns its own address
// after two cycles; every accepted beat is checked against its index.
module tb_averager_readout;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [23:0] n_avg;
    logic [31:0] period;
    logic [9:0]  bram_addr;
    logic        bram_en;
    logic [31:0] bram_rdata;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [23:0] frame_n_avg;
    logic        busy;
    logic [15:0] overrun_cnt;

    int checks = 0;
    int failures = 0;
    logic [9:0] a1, a2;

    averager_readout dut (
        .clk(clk), .rst(rst), .ready(ready), .n_avg(n_avg),
        .period(period), .bram_addr(bram_addr), .bram_en(bram_en),
        .bram_rdata(bram_rdata), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .frame_n_avg(frame_n_avg), .busy(busy), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        a1 <= bram_addr;
        a2 <= a1;
    end
    assign bram_rdata = {22'd0, a2};

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [31:0] p, input logic [23:0] n);
        ready = 1'b0;
        @(negedge clk);
        period = p;
        n_avg  = n;
        ready  = 1'b1;
    endtask

    // tmode: 0 always ready, 1 random, 2 stalled for 100 cycles
    // rmode: 0 pulse, 1 re-raise at beat 50, 2 re-raise on last accept
    task automatic collect(input int L, input int tmode, input int rmode,
                           input int rst_at);
        int idx, first_v, last_c, en_stall;
        logic stalled, hu, hl;
        logic [31:0] hd;
        idx = 0; first_v = -1; last_c = -1; en_stall = 0; stalled = 0;
        hu = 0; hl = 0; hd = '0;
        for (int c = 1; c <= 20000 && idx < L; c++) begin
            @(negedge clk);
            if (c == 1) ready = 1'b0;
            if (c == 2) begin
                n_avg  = 24'h0F0F0F;
                period = 32'd7;
            end
            case (tmode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = (c > 100);
            endcase
            if (tmode == 2 && c <= 100 && bram_en) en_stall++;
            if (m_axis_tvalid && first_v < 0) first_v = c;
            if (stalled) begin
                check("stall_valid", 64'(m_axis_tvalid), 64'd1);
                check("stall_data", 64'(m_axis_tdata), 64'(hd));
                check("stall_user", 64'(m_axis_tuser), 64'(hu));
                check("stall_last", 64'(m_axis_tlast), 64'(hl));
            end
            stalled = 0;
            if (m_axis_tvalid && idx == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                rst = 1'b0;
                return;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("beat_data", 64'(m_axis_tdata), 64'(idx));
                check("beat_user", 64'(m_axis_tuser), 64'(idx == 0));
                check("beat_last", 64'(m_axis_tlast), 64'(idx == L - 1));
                if (rmode == 1 && idx == 50) ready = 1'b1;
                if (rmode == 2 && idx == L - 1) ready = 1'b1;
                idx++;
                last_c = c;
            end else if (m_axis_tvalid) begin
                stalled = 1;
                hd = m_axis_tdata;
                hu = m_axis_tuser;
                hl = m_axis_tlast;
            end
        end
        check("beat_count", 64'(idx), 64'(L));
        if (tmode == 0) begin
            check("first_valid_cycle", 64'(first_v), 64'd4);
            check("last_beat_cycle", 64'(last_c), 64'(4 + L - 1));
        end
        if (tmode == 2) check("reads_in_stall", 64'(en_stall), 64'd4);
        @(negedge clk);
        check("busy_after_frame", 64'(busy), 64'd0);
    endtask

    initial begin
        int busy_seen, extra_valid;
        rst = 1'b1; ready = 1'b0; n_avg = '0; period = '0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_bram_en", 64'(bram_en), 64'd0);
        check("rst_overrun", 64'(overrun_cnt), 64'd0);
        check("rst_navg", 64'(frame_n_avg), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        launch(32'd255, 24'h0ABCDE);
        collect(256, 0, 0, -1);
        check("frame_navg", 64'(frame_n_avg), 64'h0ABCDE);

        launch(32'd255, 24'h000111);
        collect(256, 1, 0, -1);

        launch(32'd255, 24'h000222);
        collect(256, 2, 0, -1);
        check("overrun_none", 64'(overrun_cnt), 64'd0);

        launch(32'd255, 24'h000333);
        collect(256, 0, 1, -1);
        busy_seen = 0; extra_valid = 0;
        repeat (1000) begin
            @(negedge clk);
            if (busy) busy_seen++;
            if (m_axis_tvalid) extra_valid++;
        end
        check("held_ready_busy", 64'(busy_seen), 64'd0);
        check("held_ready_valid", 64'(extra_valid), 64'd0);
        check("overrun_one", 64'(overrun_cnt), 64'd1);

        launch(32'd20, 24'h000444);
        collect(21, 0, 2, -1);
        repeat (5) @(negedge clk);
        check("edge_on_last_busy", 64'(busy), 64'd0);
        check("overrun_two", 64'(overrun_cnt), 64'd2);

        launch(32'd0, 24'h000555);
        collect(1, 0, 0, -1);

        launch(32'd5000, 24'h000666);
        collect(1024, 0, 0, -1);
        check("frame_navg_big", 64'(frame_n_avg), 64'h000666);

        launch(32'd255, 24'h000777);
        collect(256, 0, 0, 100);
        repeat (6) @(negedge clk);
        check("post_rst_valid", 64'(m_axis_tvalid), 64'd0);
        check("post_rst_en", 64'(bram_en), 64'd0);
        check("post_rst_overrun", 64'(overrun_cnt), 64'd0);

        launch(32'd255, 24'h000888);
        collect(256, 0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
